cdb_rr_arbiter: RTL and testbench

Common Data Bus arbiter for the execution stage. Collects result requests from all execution units (load buffer, store buffer, branch unit, ALU, multiplier, divider, FPU), grants at most one per cycle with round-robin fairness, and drives a single registered CDB broadcast. The ROB and every reservation station consume that broadcast for commit bookkeeping and operand forwarding. Sits between the execution units' `cdb_valid_o`/`cdb_data_o` outputs and the ROB write port.

---
 rtl/cdb_rr_arbiter_pkg.sv | 28 ++
 rtl/cdb_rr_arbiter_if.sv | 27 ++
 rtl/cdb_rr_arbiter_grant_sel.sv | 32 +++
 rtl/cdb_rr_arbiter.sv | 103 ++++++++++
 tb/tb_cdb_rr_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_rr_arbiter_pkg.sv
// Shared configuration and execution-pipe types for the CDB arbiter slice.
//   len5_config_pkg : core-wide sizing (MAX_EU_N)
//   expipe_pkg      : execution-unit indices, CDB payload type, CDB_SRC_LEN
package len5_config_pkg;
  localparam int MAX_EU_N = 8;
endpackage

package expipe_pkg;
  import len5_config_pkg::*;

  // Requester indices on the CDB
  localparam int EU_LOAD_BUFFER  = 0;
  localparam int EU_STORE_BUFFER = 1;
  localparam int EU_BRANCH_UNIT  = 2;
  localparam int EU_INT_ALU      = 3;
  localparam int EU_INT_MULT     = 4;
  localparam int EU_INT_DIV      = 5;
  localparam int EU_FPU          = 6;
  localparam int EU_CSR          = 7;

  localparam int CDB_SRC_LEN = $clog2(MAX_EU_N);

  typedef struct packed {
    logic [5:0]  tag;            // ROB entry the result belongs to
    logic [31:0] value;
    logic        except_raised;
  } cdb_data_t;
endpackage

// File: rtl/cdb_rr_arbiter_if.sv
// CDB arbiter bus: execution-unit request/grant lanes plus the ROB-side
// broadcast. Signal names carry the arbiter's point of view (_i into it).
//   slave  : arbiter side
//   master : execution units / ROB side (and testbench)
interface cdb_rr_arbiter_if
  import expipe_pkg::*;
#(
  parameter int EU_N  = len5_config_pkg::MAX_EU_N,
  parameter int SRC_W = (EU_N > 1) ? $clog2(EU_N) : 1
);
  logic      [EU_N-1:0] eu_valid_i;
  logic      [EU_N-1:0] eu_ready_o;
  cdb_data_t [EU_N-1:0] eu_data_i;
  logic                 rob_ready_i;
  logic                 cdb_valid_o;
  cdb_data_t            cdb_data_o;
  logic      [SRC_W-1:0] cdb_src_o;

  modport slave (
    input  eu_valid_i, eu_data_i, rob_ready_i,
    output eu_ready_o, cdb_valid_o, cdb_data_o, cdb_src_o
  );
  modport master (
    output eu_valid_i, eu_data_i, rob_ready_i,
    input  eu_ready_o, cdb_valid_o, cdb_data_o, cdb_src_o
  );
endinterface

// File: rtl/cdb_rr_arbiter_grant_sel.sv
// rr_grant_sel: combinational wrap-around priority search.
//   req_i : request vector
//   ptr_i : highest-priority index this cycle
//   gnt_o : one-hot grant (zero if no request)
//   idx_o : encoded grant index
//   any_o : at least one request present
module rr_grant_sel #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);
  // Scan from the farthest position back toward ptr so the last hit,
  // i.e. the one closest to ptr going upward, is what remains.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr_i) + i) % N]) begin
        gnt_o = '0;
        gnt_o[(int'(ptr_i) + i) % N] = 1'b1;
        idx_o = W'((int'(ptr_i) + i) % N);
        any_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cdb_rr_arbiter.sv
// cdb_rr_arbiter: round-robin Common Data Bus arbiter with a registered
// broadcast stage feeding the ROB and reservation stations.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset
//   flush_i : misprediction/exception flush, kills the output entry
//   bus     : cdb_rr_arbiter_if.slave (EU request/grant, ROB ready, CDB out)
// Optional macro LEN5_CDB_BRANCH_PRIO_EN: the branch unit (BRANCH_IDX)
// pre-empts round-robin whenever it requests; the pointer is left alone.
module cdb_rr_arbiter
  import expipe_pkg::*;
#(
  parameter int EU_N       = len5_config_pkg::MAX_EU_N,
  parameter int BRANCH_IDX = expipe_pkg::EU_BRANCH_UNIT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  cdb_rr_arbiter_if.slave   bus
);
  localparam int SRC_W = (EU_N > 1) ? $clog2(EU_N) : 1;

  logic             out_valid_q, out_valid_d;
  cdb_data_t        out_data_q,  out_data_d;
  logic [SRC_W-1:0] out_src_q,   out_src_d;
  logic [SRC_W-1:0] rr_ptr_q,    rr_ptr_d;

  logic [EU_N-1:0]  sel_gnt;
  logic [SRC_W-1:0] sel_idx;
  logic             sel_any;

  logic [EU_N-1:0]  win_gnt;
  logic [SRC_W-1:0] win_idx;
  logic             win_any;
  logic             win_prio;
  logic             reg_free;
  logic             grant_ok;

  rr_grant_sel #(.N(EU_N), .W(SRC_W)) u_sel (
    .req_i (bus.eu_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (sel_gnt),
    .idx_o (sel_idx),
    .any_o (sel_any)
  );

`ifdef LEN5_CDB_BRANCH_PRIO_EN
  assign win_prio = bus.eu_valid_i[BRANCH_IDX];
  assign win_gnt  = win_prio ? (EU_N'(1) << BRANCH_IDX) : sel_gnt;
  assign win_idx  = win_prio ? SRC_W'(BRANCH_IDX) : sel_idx;
  assign win_any  = sel_any;
`else
  logic unused_branch_idx;
  assign unused_branch_idx = (BRANCH_IDX < EU_N);
  assign win_prio = 1'b0;
  assign win_gnt  = sel_gnt;
  assign win_idx  = sel_idx;
  assign win_any  = sel_any;
`endif

  // rob_ready_i reaches the grant combinationally so a retiring entry can
  // be replaced in the same edge; the broadcast itself stays registered.
  assign reg_free       = !out_valid_q || bus.rob_ready_i;
  assign grant_ok       = reg_free && !flush_i && !rst_i;
  assign bus.eu_ready_o = (grant_ok && win_any) ? win_gnt : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (reg_free) begin
      if (win_any) begin
        out_valid_d = 1'b1;
        out_data_d  = bus.eu_data_i[win_idx];
        out_src_d   = win_idx;
        if (!win_prio)
          rr_ptr_d = (win_idx == SRC_W'(EU_N - 1)) ? '0 : win_idx + SRC_W'(1);
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.cdb_valid_o = out_valid_q;
  assign bus.cdb_data_o  = out_data_q;
  assign bus.cdb_src_o   = out_src_q;
endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Bench for cdb_rr_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue-free
// behavioural model (nearest-requester-from-pointer selection).
module tb_cdb_rr_arbiter;
  import expipe_pkg::*;

  localparam int N  = 8;
  localparam int BR = 2;

  logic clk = 1'b0;
  logic rst, flush;
  always #5 clk = ~clk;

  cdb_rr_arbiter_if #(.EU_N(N)) bus ();

  cdb_rr_arbiter #(.EU_N(N), .BRANCH_IDX(BR)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // unit-side state: pending requests and their payloads
  logic [N-1:0] pend;
  cdb_data_t    dat [N];
  bit           refill = 0;

  // model state
  bit        mv = 0;
  cdb_data_t md = '0;
  int        ms = 0;
  int        mp = 0;

  // DUT outputs seen in the latest step
  logic [N-1:0] last_ready;
  logic         last_valid;
  cdb_data_t    last_data;
  logic [2:0]   last_src;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic cdb_data_t rnd_data();
    cdb_data_t d;
    d.tag = 6'($urandom);
    d.value = $urandom;
    d.except_raised = 1'($urandom);
    return d;
  endfunction

  // One cycle: drive at negedge, check #1 later, update model at posedge.
  task automatic step(input bit rr, input bit fl, input bit r);
    int g, best;
    bit any, prio, free;
    logic [N-1:0] exp_ready;
    bus.eu_valid_i  = pend;
    for (int u = 0; u < N; u++) bus.eu_data_i[u] = dat[u];
    bus.rob_ready_i = rr;
    flush = fl;
    rst   = r;
    #1;
    // winner: requester at the smallest upward distance from the pointer
    g = 0; best = N; any = 0; prio = 0;
    for (int u = 0; u < N; u++)
      if (pend[u] && ((u - mp + N) % N) < best) begin
        best = (u - mp + N) % N; g = u; any = 1;
      end
`ifdef LEN5_CDB_BRANCH_PRIO_EN
    if (pend[BR]) begin g = BR; prio = 1; end
`endif
    free = !mv || rr;
    exp_ready = (!r && !fl && free && any) ? (N'(1) << g) : '0;
    last_ready = bus.eu_ready_o;
    last_valid = bus.cdb_valid_o;
    last_data  = bus.cdb_data_o;
    last_src   = bus.cdb_src_o;
    chk("cdb_valid", 64'(last_valid), 64'(mv));
    if (mv) begin
      chk("cdb_data", 64'(last_data), 64'(md));
      chk("cdb_src", 64'(last_src), 64'(ms));
    end
    chk("eu_ready", 64'(last_ready), 64'(exp_ready));
    @(posedge clk);
    if (r) begin
      mv = 0; md = '0; ms = 0; mp = 0;
    end else if (fl) begin
      mv = 0;
    end else if (free) begin
      if (any) begin
        mv = 1; md = dat[g]; ms = g;
        if (!prio) mp = (g + 1) % N;
        if (refill) dat[g] = rnd_data();
        else pend[g] = 1'b0;
      end else begin
        mv = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    pend = '0;
    step(1, 0, 1);
    step(1, 0, 1);
  endtask

  initial begin
    cdb_data_t d2;
    pend = '0;
    for (int u = 0; u < N; u++) dat[u] = '0;
    rst = 1; flush = 0;
    bus.eu_valid_i = '0; bus.eu_data_i = '0; bus.rob_ready_i = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset then idle
    do_reset();
    step(1, 0, 0);
    chk("idle_valid", 64'(last_valid), 64'd0);
    chk("idle_ready", 64'(last_ready), 64'd0);
    chk("idle_src", 64'(last_src), 64'd0);

    // single request from unit 3, tag 5
    dat[3] = '{tag: 6'd5, value: 32'h1234_5678, except_raised: 1'b0};
    pend = 8'h08;
    step(1, 0, 0);
    chk("u3_ready", 64'(last_ready), 64'h08);
    step(1, 0, 0);
    chk("u3_valid", 64'(last_valid), 64'd1);
    chk("u3_src", 64'(last_src), 64'd3);
    chk("u3_tag", 64'(last_data.tag), 64'd5);

    // all units requesting: 0..7,0 with no gaps
    do_reset();
    refill = 1;
    for (int u = 0; u < N; u++) dat[u] = rnd_data();
    pend = '1;
    for (int k = 0; k <= N; k++) begin
      step(1, 0, 0);
      chk("rr_order", 64'(last_ready), 64'(N'(1) << (k % N)));
      if (k > 0) begin
        chk("rr_nogap", 64'(last_valid), 64'd1);
        chk("rr_src", 64'(last_src), 64'((k - 1) % N));
      end
    end
    refill = 0;

    // backpressure after grant to unit 2
    do_reset();
    d2 = '{tag: 6'd9, value: 32'hCAFE_0002, except_raised: 1'b1};
    dat[2] = d2;
    pend = 8'h04;
    step(1, 0, 0);
    chk("bp_grant2", 64'(last_ready), 64'h04);
    dat[3] = rnd_data();
    pend = 8'h08;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0);
      chk("bp_ready0", 64'(last_ready), 64'd0);
      chk("bp_stable", 64'(last_data), 64'(d2));
    end
    step(1, 0, 0);
    chk("bp_release3", 64'(last_ready), 64'h08);

    // flush with units 1 and 4 requesting while output is valid
    do_reset();
    dat[0] = rnd_data();
    pend = 8'h01;
    step(1, 0, 0);
    dat[1] = rnd_data(); dat[4] = rnd_data();
    pend = 8'h12;
    step(1, 1, 0);
    chk("fl_noready", 64'(last_ready), 64'd0);
    step(1, 0, 0);
    chk("fl_valid0", 64'(last_valid), 64'd0);
    chk("fl_ptr_held", 64'(last_ready), 64'h02);

    // branch priority vs round robin with pointer at 4
    do_reset();
    dat[3] = rnd_data();
    pend = 8'h08;
    step(1, 0, 0);
    dat[2] = rnd_data(); dat[4] = rnd_data();
    pend = 8'h14;
    step(1, 0, 0);
`ifdef LEN5_CDB_BRANCH_PRIO_EN
    chk("prio_first", 64'(last_ready), 64'h04);
    step(1, 0, 0);
    chk("prio_second", 64'(last_ready), 64'h10);
`else
    chk("rr_first", 64'(last_ready), 64'h10);
    step(1, 0, 0);
    chk("rr_second", 64'(last_ready), 64'h04);
`endif

    // reset during a stall
    do_reset();
    dat[0] = rnd_data();
    pend = 8'h01;
    step(1, 0, 0);
    step(0, 0, 0);
    chk("st_valid", 64'(last_valid), 64'd1);
    step(0, 0, 1);
    chk("st_rst_ready", 64'(last_ready), 64'd0);
    for (int u = 0; u < N; u++) dat[u] = rnd_data();
    pend = '1;
    step(0, 0, 0);
    chk("st_valid0", 64'(last_valid), 64'd0);
    chk("st_ptr0", 64'(last_ready), 64'h01);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit fl;
      for (int u = 0; u < N; u++)
        if (!pend[u] && ($urandom % 3 == 0)) begin
          pend[u] = 1'b1;
          dat[u]  = rnd_data();
        end
      fl = ($urandom % 32 == 0);
      step(($urandom % 4) != 0, fl, ($urandom % 100) == 0);
      if (fl)
        for (int u = 0; u < N; u++)
          if ($urandom % 2 == 0) pend[u] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
